// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
// Shared definitions for the PS/2 keycode decoder:
//   - set-2 scancode constants used by the prefix FSM and modifier tracking
//   - prefix_state_t, the state of the E0/F0 prefix interpreter
//   - scancode_to_ascii(), a pure translation from a make code to ASCII
//     (returns 8'h00 when the key has no printable/control character)
package ps2_kbd_pkg;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] LSHIFT   = 8'h12;
    localparam logic [7:0] RSHIFT   = 8'h59;
    localparam logic [7:0] CAPS     = 8'h58;
    localparam logic [7:0] ENTER    = 8'h5A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } prefix_state_t;

    // Letters are looked up as lower case and shifted down by 0x20 when
    // upper_letters is set; digits honour only shift (Caps Lock does not
    // affect them). Extended codes only know keypad Enter.
    function automatic logic [7:0] scancode_to_ascii(
        input logic [7:0] code,
        input logic       ext,
        input logic       upper_letters,
        input logic       shift
    );
        logic [7:0] letter;
        logic [7:0] result;
        letter = 8'h00;
        result = 8'h00;
        if (ext) begin
            result = (code == ENTER) ? 8'h0D : 8'h00;
        end else begin
            case (code)
                8'h1C: letter = 8'h61; // a
                8'h32: letter = 8'h62; // b
                8'h21: letter = 8'h63; // c
                8'h23: letter = 8'h64; // d
                8'h24: letter = 8'h65; // e
                8'h2B: letter = 8'h66; // f
                8'h34: letter = 8'h67; // g
                8'h33: letter = 8'h68; // h
                8'h43: letter = 8'h69; // i
                8'h3B: letter = 8'h6A; // j
                8'h42: letter = 8'h6B; // k
                8'h4B: letter = 8'h6C; // l
                8'h3A: letter = 8'h6D; // m
                8'h31: letter = 8'h6E; // n
                8'h44: letter = 8'h6F; // o
                8'h4D: letter = 8'h70; // p
                8'h15: letter = 8'h71; // q
                8'h2D: letter = 8'h72; // r
                8'h1B: letter = 8'h73; // s
                8'h2C: letter = 8'h74; // t
                8'h3C: letter = 8'h75; // u
                8'h2A: letter = 8'h76; // v
                8'h1D: letter = 8'h77; // w
                8'h22: letter = 8'h78; // x
                8'h35: letter = 8'h79; // y
                8'h1A: letter = 8'h7A; // z
                default: letter = 8'h00;
            endcase
            if (letter != 8'h00) begin
                result = upper_letters ? (letter - 8'h20) : letter;
            end else begin
                case (code)
                    8'h16: result = shift ? 8'h21 : 8'h31; // 1 !
                    8'h1E: result = shift ? 8'h40 : 8'h32; // 2 @
                    8'h26: result = shift ? 8'h23 : 8'h33; // 3 #
                    8'h25: result = shift ? 8'h24 : 8'h34; // 4 $
                    8'h2E: result = shift ? 8'h25 : 8'h35; // 5 %
                    8'h36: result = shift ? 8'h5E : 8'h36; // 6 ^
                    8'h3D: result = shift ? 8'h26 : 8'h37; // 7 &
                    8'h3E: result = shift ? 8'h2A : 8'h38; // 8 *
                    8'h46: result = shift ? 8'h28 : 8'h39; // 9 (
                    8'h45: result = shift ? 8'h29 : 8'h30; // 0 )
                    8'h29: result = 8'h20;                 // space
                    8'h5A: result = 8'h0D;                 // Enter
                    8'h66: result = 8'h08;                 // Backspace
                    8'h0D: result = 8'h09;                 // Tab
                    8'h76: result = 8'h1B;                 // Esc
                    default: result = 8'h00;
                endcase
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// kbd_char_fifo
// Synchronous FIFO for decoded characters.
//   clk, rst   : system clock, synchronous active-high reset
//   push/data  : write request and write data
//   pop        : read request (ignored while empty)
//   head       : entry at the read pointer
//   full/empty : occupancy flags
//   count      : occupancy, log2(DEPTH)+1 bits
// A push while full is accepted only if a pop happens in the same cycle;
// the slot being freed is the one the write lands in.
module kbd_char_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign full      = (count_r == CNT_FULL);
    assign count     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= data;
        end
    end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder
// Turns PS/2 set-2 scancodes from the frame receiver into ASCII characters.
//   clk, rst      : system clock, synchronous active-high reset
//   ps2_scancode  : receiver scancode, stable while ps2_valid is high
//   ps2_valid     : receiver frame-valid level (asynchronous to clk)
//   key_ascii     : character at FIFO head (0x00 while empty)
//   key_valid     : FIFO not empty
//   key_ready     : consumer pops the head this cycle
//   overflow      : sticky, a character was dropped on a full FIFO
//   shift_active  : either Shift key held
//   caps_active   : Caps Lock toggle state
// ps2_valid is synchronized; its rising edge raises a one-cycle strobe and
// captures the scancode. The prefix FSM consumes the captured code on the
// following edge, and any resulting character lands in the FIFO on that
// same edge.
module ps2_keycode_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2_scancode,
    input  logic       ps2_valid,
    output logic [7:0] key_ascii,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow,
    output logic       shift_active,
    output logic       caps_active
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   strobe_r;
    logic [7:0]             code_r;
    prefix_state_t          state_r;
    logic                   shift_r;
    logic                   caps_r;
    logic                   caps_held_r;
    logic                   overflow_r;

    logic                   make_s;
    logic                   ext_make_s;
    logic                   brk_s;
    logic                   is_shift_s;
    logic                   is_caps_s;
    logic [7:0]             ascii_s;
    logic                   push_s;
    logic                   drop_s;
    logic [7:0]             fifo_head_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [CW-1:0]          fifo_count_s;

    // Synchronizer and rising-edge capture. Reset loads ones so that a
    // frame-valid level already high at reset release is not a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r   <= {SYNC_STAGES{1'b1}};
            prev_r   <= 1'b1;
            strobe_r <= 1'b0;
            code_r   <= 8'h00;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], ps2_valid};
            prev_r   <= sync_r[SYNC_STAGES-1];
            strobe_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
            if (sync_r[SYNC_STAGES-1] & ~prev_r) begin
                code_r <= ps2_scancode;
            end else begin
                code_r <= code_r;
            end
        end
    end

    // Classify the captured code according to the current prefix state.
    always_comb begin
        make_s     = 1'b0;
        ext_make_s = 1'b0;
        brk_s      = 1'b0;
        if (strobe_r) begin
            case (state_r)
                IDLE:    make_s     = (code_r != CODE_EXT) && (code_r != CODE_BRK);
                EXT:     ext_make_s = (code_r != CODE_EXT) && (code_r != CODE_BRK);
                BRK:     brk_s      = (code_r != CODE_BRK);
                EXT_BRK: make_s     = 1'b0;
                default: make_s     = 1'b0;
            endcase
        end else begin
            make_s = 1'b0;
        end
    end

    assign is_shift_s = (code_r == LSHIFT) || (code_r == RSHIFT);
    assign is_caps_s  = (code_r == CAPS);
    assign ascii_s    = scancode_to_ascii(code_r, ext_make_s, shift_r ^ caps_r, shift_r);
    assign push_s     = ((make_s && !is_shift_s && !is_caps_s) || ext_make_s)
                        && (ascii_s != 8'h00);
    // While full the FIFO is non-empty, so key_ready alone decides the pop.
    assign drop_s     = push_s && fifo_full_s && !key_ready;

    // Prefix FSM plus modifier and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_r     <= 1'b0;
            caps_r      <= 1'b0;
            caps_held_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (strobe_r) begin
                case (state_r)
                    IDLE: begin
                        if (code_r == CODE_EXT) begin
                            state_r <= EXT;
                        end else if (code_r == CODE_BRK) begin
                            state_r <= BRK;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    EXT: begin
                        if (code_r == CODE_BRK) begin
                            state_r <= EXT_BRK;
                        end else if (code_r == CODE_EXT) begin
                            state_r <= EXT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    BRK: begin
                        if (code_r == CODE_BRK) begin
                            state_r <= BRK;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    EXT_BRK: state_r <= IDLE;
                    default: state_r <= IDLE;
                endcase
            end else begin
                state_r <= state_r;
            end

            if (make_s && is_shift_s) begin
                shift_r <= 1'b1;
            end else if (brk_s && is_shift_s) begin
                shift_r <= 1'b0;
            end else begin
                shift_r <= shift_r;
            end

            // caps_held suppresses re-toggling on typematic repeats.
            if (make_s && is_caps_s && !caps_held_r) begin
                caps_r      <= ~caps_r;
                caps_held_r <= 1'b1;
            end else if (brk_s && is_caps_s) begin
                caps_r      <= caps_r;
                caps_held_r <= 1'b0;
            end else begin
                caps_r      <= caps_r;
                caps_held_r <= caps_held_r;
            end

            overflow_r <= overflow_r | drop_s;
        end
    end

    kbd_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .data  (ascii_s),
        .pop   (key_ready),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign key_valid    = (fifo_count_s != {CW{1'b0}});
    assign key_ascii    = fifo_empty_s ? 8'h00 : fifo_head_s;
    assign overflow     = overflow_r;
    assign shift_active = shift_r;
    assign caps_active  = caps_r;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Testbench for ps2_keycode_decoder: scenario tasks against a keyboard
// model built from lookup tables and a character queue.
module tb_ps2_keycode_decoder;

    localparam int SYNC  = 2;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2_scancode;
    logic       ps2_valid;
    logic [7:0] key_ascii;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;
    logic       shift_active;
    logic       caps_active;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    bit m_ext, m_brk, m_shift, m_caps, m_caps_held;
    bit rnd_done;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46, 8'h45};
    logic [7:0] digit_chars [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
        8'h38, 8'h39, 8'h30};
    logic [7:0] digit_syms  [10] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
        8'h2A, 8'h28, 8'h29};
    logic [7:0] key_pool    [16] = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h16, 8'h1E, 8'h45,
        8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76, 8'h12, 8'h59, 8'h58, 8'h55};

    ps2_keycode_decoder #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_scancode (ps2_scancode),
        .ps2_valid    (ps2_valid),
        .key_ascii    (key_ascii),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .overflow     (overflow),
        .shift_active (shift_active),
        .caps_active  (caps_active)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_char(input logic [7:0] c, input bit ext);
        if (ext) return (c == 8'h5A) ? 8'h0D : 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c)
                return (m_shift ^ m_caps) ? 8'(65 + i) : 8'(97 + i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c)
                return m_shift ? digit_syms[i] : digit_chars[i];
        case (c)
            8'h29:   return 8'h20;
            8'h5A:   return 8'h0D;
            8'h66:   return 8'h08;
            8'h0D:   return 8'h09;
            8'h76:   return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_feed(input logic [7:0] c);
        logic [7:0] ch;
        if (m_ext && m_brk) begin
            m_ext = 0; m_brk = 0;
        end else if (m_brk) begin
            if (c != 8'hF0) begin
                if (c == 8'h12 || c == 8'h59) m_shift = 0;
                else if (c == 8'h58) m_caps_held = 0;
                m_brk = 0;
            end
        end else if (m_ext) begin
            if (c == 8'hF0) m_brk = 1;
            else if (c != 8'hE0) begin
                ch = model_char(c, 1);
                if (ch != 8'h00) exp_q.push_back(ch);
                m_ext = 0;
            end
        end else begin
            if (c == 8'hE0) m_ext = 1;
            else if (c == 8'hF0) m_brk = 1;
            else if (c == 8'h12 || c == 8'h59) m_shift = 1;
            else if (c == 8'h58) begin
                if (!m_caps_held) begin m_caps = !m_caps; m_caps_held = 1; end
            end else begin
                ch = model_char(c, 0);
                if (ch != 8'h00) exp_q.push_back(ch);
            end
        end
    endtask

    // ---------------- output monitor ----------------
    initial begin
        bit armed;
        logic [7:0] held;
        armed = 0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && key_valid && key_ready) got_q.push_back(key_ascii);
            if (!rst && armed && key_valid) begin
                tests++;
                if (key_ascii !== held) begin
                    fails++;
                    $display("FAIL head_stable: key_ascii=%02h required %02h", key_ascii, held);
                end
            end
            armed = !rst && key_valid && !key_ready;
            held  = key_ascii;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_code(input logic [7:0] c);
        int hi, lo;
        hi = $urandom_range(2, 4);
        lo = $urandom_range(5, 7);
        @(posedge clk); #1;
        ps2_scancode = c;
        ps2_valid = 1'b1;
        repeat (hi) @(posedge clk);
        #1 ps2_valid = 1'b0;
        repeat (lo) @(posedge clk);
        model_feed(c);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_ext = 0; m_brk = 0; m_shift = 0; m_caps = 0; m_caps_held = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_output(input string name);
        int budget;
        @(posedge clk); #1 key_ready = 1'b1;
        budget = 0;
        while (got_q.size() < exp_q.size() && budget < 300) begin
            @(posedge clk); budget++;
        end
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d chars, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s_char[%0d]: got %02h, required %02h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; ps2_valid = 1'b0; ps2_scancode = 8'h00; key_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_bit("reset_key_valid", key_valid, 1'b0);
        check_bit("reset_overflow", overflow, 1'b0);
        check_bit("reset_shift", shift_active, 1'b0);
        check_bit("reset_caps", caps_active, 1'b0);
        tests++;
        if (key_ascii !== 8'h00) begin
            fails++;
            $display("FAIL reset_key_ascii: got %02h, required 00", key_ascii);
        end
    endtask

    task automatic test_basic();
        int edges;
        key_ready = 1'b0;
        @(posedge clk); #1;
        ps2_scancode = 8'h1C;
        ps2_valid = 1'b1;
        edges = 0;
        while (edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (key_valid) break;
        end
        tests++;
        if (edges != SYNC + 2) begin
            fails++;
            $display("FAIL latency: got %0d edges, required %0d", edges, SYNC + 2);
        end
        ps2_valid = 1'b0;
        repeat (6) @(posedge clk);
        model_feed(8'h1C);
        send_code(8'hF0);
        send_code(8'h1C);
        check_output("basic");
    endtask

    task automatic test_shift();
        send_code(8'h12);
        check_bit("shift_held", shift_active, 1'b1);
        send_code(8'h1C);
        send_code(8'hF0);
        send_code(8'h1C);
        send_code(8'hF0);
        send_code(8'h12);
        send_code(8'h1C);
        check_bit("shift_released", shift_active, 1'b0);
        check_output("shift");
    endtask

    task automatic test_caps();
        send_code(8'h58);
        check_bit("caps_first", caps_active, 1'b1);
        send_code(8'h58);
        check_bit("caps_typematic", caps_active, 1'b1);
        send_code(8'hF0);
        send_code(8'h58);
        send_code(8'h12);
        send_code(8'h1C);
        send_code(8'h16);
        send_code(8'hF0);
        send_code(8'h12);
        check_bit("caps_after", caps_active, 1'b1);
        check_output("caps");
    endtask

    task automatic test_extended();
        send_code(8'hE0); send_code(8'h75);
        send_code(8'hE0); send_code(8'hF0); send_code(8'h75);
        send_code(8'hE0); send_code(8'h5A);
        check_output("extended");
        send_code(8'h1C);
        check_output("ext_idle");
    endtask

    task automatic test_overflow();
        do_reset();
        key_ready = 1'b0;
        repeat (9) send_code(8'h1C);
        exp_q.pop_back();
        check_bit("overflow_set", overflow, 1'b1);
        check_bit("overflow_valid", key_valid, 1'b1);
        // Time a pop to coincide with the push of a new character.
        @(posedge clk); #1;
        ps2_scancode = 8'h32;
        ps2_valid = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1 key_ready = 1'b1;
        @(posedge clk);
        #1 key_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ps2_valid = 1'b0;
        repeat (6) @(posedge clk);
        model_feed(8'h32);
        check_bit("overflow_sticky", overflow, 1'b1);
        check_output("overflow");
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b0;
        send_code(8'h12);
        send_code(8'h1C);
        send_code(8'hF0);
        do_reset();
        #1;
        check_bit("mid_overflow", overflow, 1'b0);
        check_bit("mid_shift", shift_active, 1'b0);
        check_bit("mid_valid", key_valid, 1'b0);
        // Frame-valid high across reset release must not be captured.
        @(posedge clk); #1;
        ps2_scancode = 8'h1C;
        ps2_valid = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 ps2_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_bit("mid_inflight", key_valid, 1'b0);
        send_code(8'h1C);
        check_output("reset_mid");
    endtask

    task automatic test_random();
        do_reset();
        rnd_done = 0;
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    int kind;
                    logic [7:0] k;
                    kind = $urandom_range(0, 9);
                    k = key_pool[$urandom_range(0, 15)];
                    if (kind <= 5) send_code(k);
                    else if (kind <= 7) begin send_code(8'hF0); send_code(k); end
                    else if (kind == 8) begin
                        send_code(8'hE0);
                        send_code(($urandom_range(0, 1) == 1) ? 8'h5A : 8'h75);
                    end else begin
                        send_code(8'hE0); send_code(8'hF0); send_code(8'h75);
                    end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1 key_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        check_output("random");
        check_bit("random_shift", shift_active, 1'(m_shift));
        check_bit("random_caps", caps_active, 1'(m_caps));
        check_bit("random_overflow", overflow, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_caps();
        test_extended();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_decoder.md
Name: ps2_keycode_decoder

Overview:
Downstream consumer of the PS/2 frame receiver. It takes each validated 8-bit scancode, which is generated in the PS/2 clock domain, and brings it into the system clock domain. It then interprets the set-2 prefixes (E0 extended, F0 break), tracks Shift and Caps Lock, and translates make codes into ASCII. The resulting characters are buffered in a small FIFO and offered to the CPU through a valid/ready interface.

Parameters:
FIFO_DEPTH, 8, number of buffered ASCII characters; must be a power of 2, minimum 2.
SYNC_STAGES, 2, flop count in the ps2_valid synchronizer; minimum 2.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
ps2_scancode  input  8  scancode from the frame receiver; stable for the whole time ps2_valid is high.
ps2_valid  input  1  frame-valid level from the receiver; asynchronous to clk; high for one or more PS/2 clock periods.
key_ascii  output  8  ASCII character at the FIFO head.
key_valid  output  1  FIFO not empty.
key_ready  input  1  consumer accepts key_ascii in this cycle.
overflow  output  1  sticky: at least one character was dropped.
shift_active  output  1  left or right Shift is currently held.
caps_active  output  1  Caps Lock toggle state.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Synchronizer flops and the previous-value flop are set to 1. A ps2_valid pulse already in progress at reset release is therefore ignored, and only a genuine 0->1 transition is detected afterwards.
  - Prefix FSM returns to IDLE.
  - shift_active=0, caps_active=0, caps_held=0.
  - FIFO is emptied: key_valid=0, key_ascii=0x00.
  - overflow=0.
- Capture: a rising edge of synchronized ps2_valid raises a one-cycle strobe, and ps2_scancode is registered on that same edge. At most one code is captured per ps2_valid high period.
- Latency: with an empty FIFO, key_valid rises exactly SYNC_STAGES+2 clk edges after the first edge that samples ps2_valid=1.
- Prefix FSM (advances only on a capture strobe):
  - IDLE: E0 -> EXT; F0 -> BRK; any other code is a make code and is processed.
  - EXT: F0 -> EXT_BRK; any other code is an extended make, processed, then -> IDLE.
  - BRK: the code is a break; release processing, then -> IDLE.
  - EXT_BRK: the code is ignored, then -> IDLE.
  - A repeated E0 in EXT stays in EXT. A repeated F0 in BRK stays in BRK.
- Make processing:
  - 0x12 or 0x59: set shift_active.
  - 0x58: if caps_held=0, toggle caps_active and set caps_held. Typematic repeats therefore do not re-toggle.
  - Otherwise, look the code up in the ASCII table; a non-zero result is pushed into the FIFO. Typematic repeats push again.
- Release processing:
  - 0x12 or 0x59: clear shift_active. Shift is not tracked per side.
  - 0x58: clear caps_held.
  - Any other break code: no effect.
- ASCII table:
  - Letters: 'A'..'Z' when shift_active XOR caps_active, otherwise 'a'..'z'.
  - Digits 0-9: with shift_active they give US shifted symbols (!@#$%^&*()). Caps Lock has no effect on digits.
  - 0x29 -> 0x20 (space).
  - 0x5A -> 0x0D (Enter).
  - 0x66 -> 0x08 (Backspace).
  - 0x0D -> 0x09 (Tab).
  - 0x76 -> 0x1B (Esc).
  - Unlisted codes -> 0x00, which means no push.
- Extended makes: only E0 5A (keypad Enter) -> 0x0D. All other extended makes produce nothing.
- FIFO:
  - Pop when key_valid & key_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full.
  - A push while full with no pop drops the new character, keeps all stored ones, and sets overflow. overflow stays set until rst.
  - Read and write pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a log2(FIFO_DEPTH)+1 bit count.
  - key_ascii shows the head entry while key_valid=1 and must not change until that entry is popped.
- Reset mid-operation: reset takes precedence over a concurrent capture strobe or push, and a partially received prefix sequence is discarded.

Decomposition:
- Package ps2_kbd_pkg holds:
  - code constants: CODE_EXT=0xE0, CODE_BRK=0xF0, LSHIFT=0x12, RSHIFT=0x59, CAPS=0x58, ENTER=0x5A.
  - the prefix-state enum: IDLE, EXT, BRK, EXT_BRK.
  - the pure function scancode_to_ascii(code, ext, upper_letters, shift) returning 8 bits.
- One sub-module, kbd_char_fifo. It is a parameterized synchronous FIFO with push, pop, data, full, empty and count.
- The synchronizer, edge detect and FSM stay in the top module.

Test Plan:
- Codes 1C, F0, 1C -> exactly one character, 0x61 'a'; key_valid rises SYNC_STAGES+2 edges after ps2_valid. The break produces nothing.
- Codes 12, 1C, F0, 1C, F0, 12, 1C -> characters 0x41 then 0x61; shift_active goes 1 then back to 0.
- Codes 58, 58 (typematic), F0, 58, 1C, 16 with Shift held -> caps_active=1 after the first 58 only; then 1C with Shift held -> 0x61, and 16 -> '!' (0x21).
- Codes E0, 75, E0, F0, 75, E0, 5A -> only 0x0D; FSM back in IDLE; no stray characters.
- key_ready=0; nine 1C makes with FIFO_DEPTH=8 -> 8 entries, overflow=1. Draining yields eight 0x61 characters; a push plus pop while full then keeps count at 8.
- Send F0, assert rst for one cycle, then send 1C -> output 0x61, meaning the pending break was discarded. overflow=0 and shift_active=0 after reset.
